// File: rtl/shift_sequencer_if.sv
// Handshake bundle between decode, the shift sequencer and ALU writeback.
// The master drives the op and out_ready; the slave (sequencer) returns result and status.
interface shift_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       funct;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             illegal;
  logic             busy;

  modport master (
    output in_valid, funct, shamt, rs, rt, out_ready,
    input  in_ready, out_valid, result, illegal, busy
  );

  modport slave (
    input  in_valid, funct, shamt, rs, rt, out_ready,
    output in_ready, out_valid, result, illegal, busy
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter for the R-type shift group: one bit per clock, result
// returned over a valid/ready handshake. Illegal funct codes complete immediately.
//
// state   | meaning
// S_IDLE  | waiting for an op, in_ready high
// S_SHIFT | shifting data by one bit per clock until count expires
// S_DONE  | result/illegal presented, waiting for out_ready
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic               clk,
  input  logic               reset,
  shift_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [SHW:0] CNT_ONE = {{SHW{1'b0}}, 1'b1};

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_op;
  logic [SHW:0]     r_count;
  logic             r_illegal;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_legal;
  logic [SHW:0]     w_amt;
  logic             w_accept;
  logic [WIDTH-1:0] w_shifted;
  logic             w_unused_rs;

  always_comb begin
    w_legal = 1'b0;
    case (bus.funct)
      6'b000000, 6'b000010, 6'b000011,
      6'b000100, 6'b000110, 6'b000111: w_legal = 1'b1;
      default:                         w_legal = 1'b0;
    endcase
  end

  // Variable forms take the amount from rs; only the low SHW bits matter.
  assign w_amt       = bus.funct[2] ? {1'b0, bus.rs[SHW-1:0]} : {1'b0, bus.shamt};
  assign w_unused_rs = ^bus.rs[WIDTH-1:SHW];
  assign w_accept    = bus.in_valid & r_in_ready;

  always_comb begin
    w_shifted = r_data;
    case (r_op)
      2'b00:   w_shifted = {r_data[WIDTH-2:0], 1'b0};
      2'b10:   w_shifted = {1'b0, r_data[WIDTH-1:1]};
      2'b11:   w_shifted = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
      default: w_shifted = r_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_op        <= 2'b00;
      r_count     <= '0;
      r_illegal   <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_data     <= bus.rt;
            r_op       <= bus.funct[1:0];
            r_count    <= w_amt;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (!w_legal) begin
              r_illegal   <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else if (w_amt == '0) begin
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_data  <= w_shifted;
          r_count <= r_count - CNT_ONE;
          if (r_count == CNT_ONE) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          // Draining goes to IDLE only; a new op waits at least one cycle.
          if (bus.out_ready) begin
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_data;
  assign bus.illegal   = r_illegal;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: a driver pushes model results, a monitor
// pops and compares them (value, illegal flag, first-valid cycle) at each handshake.
module tb_shift_sequencer;
  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_sequencer_if #(.WIDTH(WIDTH), .SHW(SHW)) bus_if ();
  shift_sequencer #(.WIDTH(WIDTH), .SHW(SHW)) dut (.clk(clk), .reset(reset), .bus(bus_if));

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             ill;
    int               due;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   rdy_mode = 0;  // 0 random, 1 held low, 2 held high
  logic prev_ov = 1'b0;
  logic [5:0] legal_f [6] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Reference: whole-amount shift with SV operators, latency = amount.
  function automatic exp_t model(input logic [5:0] f, input logic [SHW-1:0] sh,
                                 input logic [WIDTH-1:0] rsv, input logic [WIDTH-1:0] rtv,
                                 input int accept_cyc);
    exp_t e;
    int amt;
    bit legal;
    legal = 1'b0;
    foreach (legal_f[i]) if (f == legal_f[i]) legal = 1'b1;
    amt = f[2] ? int'(rsv % WIDTH) : int'(sh);
    e.ill = !legal;
    e.res = rtv;
    e.due = accept_cyc;
    if (legal) begin
      e.due = accept_cyc + amt;
      if (f[1:0] == 2'b00)      e.res = rtv << amt;
      else if (f[1:0] == 2'b10) e.res = rtv >> amt;
      else                      e.res = WIDTH'($signed(rtv) >>> amt);
    end
    return e;
  endfunction

  initial begin
    bus_if.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0)      bus_if.out_ready = 1'($urandom_range(0, 1));
      else if (rdy_mode == 1) bus_if.out_ready = 1'b0;
      else                    bus_if.out_ready = 1'b1;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ov = 1'b0;
      end else begin
        if (bus_if.out_valid && !prev_ov) begin
          if (sb.size() == 0) timeout("unexpected_out_valid");
          else check("first_valid_cycle", WIDTH'(cyc), WIDTH'(sb[0].due));
        end
        if (bus_if.out_valid && bus_if.out_ready) begin
          if (sb.size() == 0) begin
            timeout("handshake_without_expected");
          end else begin
            e = sb.pop_front();
            check("result", bus_if.result, e.res);
            check("illegal", WIDTH'(bus_if.illegal), WIDTH'(e.ill));
          end
        end
        prev_ov = bus_if.out_valid;
      end
    end
  end

  // Called and returns at posedge+#1.
  task automatic send_op(input logic [5:0] f, input logic [SHW-1:0] sh,
                         input logic [WIDTH-1:0] rsv, input logic [WIDTH-1:0] rtv);
    logic acc;
    acc = 1'b0;
    bus_if.funct    = f;
    bus_if.shamt    = sh;
    bus_if.rs       = rsv;
    bus_if.rt       = rtv;
    bus_if.in_valid = 1'b1;
    for (int i = 0; i < 400 && !acc; i++) begin
      acc = bus_if.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      timeout("accept");
    end else begin
      sb.push_back(model(f, sh, rsv, rtv, cyc));
    end
    bus_if.in_valid = 1'b0;
    bus_if.funct    = 6'($urandom);
    bus_if.shamt    = SHW'($urandom);
    bus_if.rs       = $urandom;
    bus_if.rt       = $urandom;
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 400; i++) begin
      if (sb.size() == 0 && bus_if.in_ready) break;
      @(posedge clk);
      #1;
    end
    if (i == 400) timeout("drain");
  endtask

  initial begin
    logic [WIDTH-1:0] hold;
    int k;
    logic [5:0] f;
    reset            = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.funct     = '0;
    bus_if.shamt     = '0;
    bus_if.rs        = '0;
    bus_if.rt        = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", WIDTH'(bus_if.in_ready), '0);
    check("rst_out_valid", WIDTH'(bus_if.out_valid), '0);
    check("rst_busy", WIDTH'(bus_if.busy), '0);
    check("rst_result", bus_if.result, '0);
    check("rst_illegal", WIDTH'(bus_if.illegal), '0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", WIDTH'(bus_if.in_ready), 32'd1);

    rdy_mode = 2;
    send_op(6'b000000, 5'd31, 32'h0, 32'h00000001);
    wait_drain();
    check("sll31_idle_result", bus_if.result, 32'h80000000);
    send_op(6'b000011, 5'd4, 32'h0, 32'h80000000);
    send_op(6'b000010, 5'd4, 32'h0, 32'h80000000);
    send_op(6'b000110, 5'd9, 32'h00000025, 32'hF0000000);
    wait_drain();
    check("srlv_idle_result", bus_if.result, 32'h07800000);
    send_op(6'b000000, 5'd0, 32'h0, 32'h12345678);
    send_op(6'b100000, 5'd7, 32'h0, 32'hDEADBEEF);
    send_op(6'b000100, 5'd0, 32'hFFFFFFE3, 32'h0000000F);
    send_op(6'b000111, 5'd0, 32'h0000001F, 32'h80000000);
    wait_drain();

    rdy_mode = 1;
    send_op(6'b000011, 5'd9, 32'h0, 32'h87654321);
    for (k = 0; k < 40 && !bus_if.out_valid; k++) begin
      @(posedge clk);
      #1;
    end
    if (!bus_if.out_valid) timeout("done_wait");
    hold = bus_if.result;
    repeat (10) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", WIDTH'(bus_if.out_valid), 32'd1);
      check("hold_in_ready", WIDTH'(bus_if.in_ready), '0);
      check("hold_result", bus_if.result, hold);
    end
    rdy_mode         = 2;
    bus_if.out_ready = 1'b1;
    bus_if.funct     = 6'b000000;
    bus_if.shamt     = 5'd2;
    bus_if.rt        = 32'h1;
    bus_if.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    check("drain_out_valid", WIDTH'(bus_if.out_valid), '0);
    check("drain_not_accepted_busy", WIDTH'(bus_if.busy), '0);
    check("drain_in_ready", WIDTH'(bus_if.in_ready), 32'd1);
    wait_drain();

    send_op(6'b000000, 5'd20, 32'h0, 32'h00000001);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    check("midrst_out_valid", WIDTH'(bus_if.out_valid), '0);
    check("midrst_busy", WIDTH'(bus_if.busy), '0);
    check("midrst_result", bus_if.result, '0);
    check("midrst_in_ready", WIDTH'(bus_if.in_ready), '0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_release_in_ready", WIDTH'(bus_if.in_ready), 32'd1);
    repeat (25) begin
      @(posedge clk);
      #1;
      check("no_stale_out_valid", WIDTH'(bus_if.out_valid), '0);
    end
    send_op(6'b000010, 5'd3, 32'h0, 32'h000000F0);
    wait_drain();

    rdy_mode = 0;
    for (int n = 0; n < 150; n++) begin
      k = int'($urandom_range(0, 7));
      f = (k < 6) ? legal_f[k] : 6'($urandom);
      send_op(f, SHW'($urandom), $urandom, $urandom);
    end
    wait_drain();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
